// File: rtl/fxp_mac_pe.sv
// Fixed-point multiply-accumulate processing element with a shifting row buffer.
// Issue -> rounded product (edge N+1) -> accumulate (edge N+2), optional saturation.
module fxp_mac_pe #(
    parameter int unsigned W     = 8,
    parameter int unsigned FRAC  = 3,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned SAT   = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en_in,
    input  logic         in_row,
    input  logic [W-1:0] in_data,
    input  logic         acc_clr,
    input  logic         en_out,
    output logic [W-1:0] out_data,
    output logic         out_vld,
    output logic         acc_upd,
    output logic         ovf
);

    localparam int unsigned PW = 2 * W + 1;
    localparam int unsigned HW = PW - W + 1;
    localparam logic [PW-1:0] RND_HALF = PW'(1) << (FRAC - 1);
    localparam logic [W-1:0]  VAL_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  VAL_MIN  = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] row_buf_q [DEPTH];
    logic [W-1:0] row_buf_d [DEPTH];
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         iss_q, iss_d;
    logic [W-1:0] p_q, p_d;
    logic         p_vld_q, p_vld_d;
    logic [W-1:0] acc_q, acc_d;
    logic         acc_upd_q, acc_upd_d;
    logic         ovf_q, ovf_d;

    logic signed [PW-1:0] prod_full;
    logic signed [PW-1:0] prod_rnd;
    logic signed [PW-1:0] prod_shr;
    logic [HW-2:0]        prod_hi;
    logic                 prod_ovf;
    logic [W-1:0]         prod_fit;
    logic [W:0]           acc_sum;
    logic                 acc_ovf;
    logic [W-1:0]         acc_fit;

    // Row buffer shift, operand capture and issue tracking
    always_comb begin
        row_buf_d = row_buf_q;
        a_d       = a_q;
        b_d       = b_q;
        iss_d     = 1'b0;
        if (en_in && in_row) begin
            row_buf_d[0] = in_data;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                row_buf_d[k] = row_buf_q[k-1];
            end
        end
        if (en_in && !in_row) begin
            a_d   = row_buf_q[DEPTH-1];
            b_d   = in_data;
            iss_d = 1'b1;
        end
    end

    // Full-precision product, round half up, then shift back to the operand scale
    always_comb begin
        prod_full = $signed({{(W+1){a_q[W-1]}}, a_q}) * $signed({{(W+1){b_q[W-1]}}, b_q});
        prod_rnd  = prod_full + $signed(RND_HALF);
        prod_shr  = prod_rnd >>> FRAC;
        prod_hi   = prod_shr[PW-1:W-1];
        prod_ovf  = !((&prod_hi) || !(|prod_hi));
        prod_fit  = prod_shr[W-1:0];
        if (prod_ovf && (SAT != 0)) begin
            prod_fit = prod_shr[PW-1] ? VAL_MIN : VAL_MAX;
        end
    end

    // Accumulator adder with one guard bit for overflow detection
    always_comb begin
        acc_sum = {acc_q[W-1], acc_q} + {p_q[W-1], p_q};
        acc_ovf = acc_sum[W] ^ acc_sum[W-1];
        acc_fit = acc_sum[W-1:0];
        if (acc_ovf && (SAT != 0)) begin
            acc_fit = acc_sum[W] ? VAL_MIN : VAL_MAX;
        end
    end

    // Pipeline stages; clear-then-add when acc_clr meets an accumulate edge
    always_comb begin
        p_d       = p_q;
        p_vld_d   = iss_q;
        acc_d     = acc_q;
        acc_upd_d = p_vld_q;
        ovf_d     = acc_clr ? 1'b0 : ovf_q;
        if (iss_q) begin
            p_d = prod_fit;
            if (prod_ovf) begin
                ovf_d = 1'b1;
            end
        end
        if (p_vld_q) begin
            if (acc_clr) begin
                acc_d = p_q;
            end else begin
                acc_d = acc_fit;
                if (acc_ovf) begin
                    ovf_d = 1'b1;
                end
            end
        end else if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                row_buf_q[k] <= '0;
            end
            a_q       <= '0;
            b_q       <= '0;
            iss_q     <= 1'b0;
            p_q       <= '0;
            p_vld_q   <= 1'b0;
            acc_q     <= '0;
            acc_upd_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                row_buf_q[k] <= row_buf_d[k];
            end
            a_q       <= a_d;
            b_q       <= b_d;
            iss_q     <= iss_d;
            p_q       <= p_d;
            p_vld_q   <= p_vld_d;
            acc_q     <= acc_d;
            acc_upd_q <= acc_upd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_data = en_out ? acc_q : '0;
    assign out_vld  = en_out;
    assign acc_upd  = acc_upd_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_fxp_mac_pe.sv
// Directed bench for fxp_mac_pe (W=8, FRAC=3, DEPTH=3); a wrap-around copy runs alongside.
module tb_fxp_mac_pe;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en_in, in_row, acc_clr, en_out;
    logic [7:0] in_data;
    logic [7:0] out_data, out_data_w;
    logic       out_vld, out_vld_w;
    logic       acc_upd, acc_upd_w;
    logic       ovf, ovf_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fxp_mac_pe #(.W(8), .FRAC(3), .DEPTH(3), .SAT(1)) dut (
        .clk(clk), .rstn(rstn), .en_in(en_in), .in_row(in_row), .in_data(in_data),
        .acc_clr(acc_clr), .en_out(en_out), .out_data(out_data), .out_vld(out_vld),
        .acc_upd(acc_upd), .ovf(ovf)
    );

    fxp_mac_pe #(.W(8), .FRAC(3), .DEPTH(3), .SAT(0)) dut_wrap (
        .clk(clk), .rstn(rstn), .en_in(en_in), .in_row(in_row), .in_data(in_data),
        .acc_clr(acc_clr), .en_out(en_out), .out_data(out_data_w), .out_vld(out_vld_w),
        .acc_upd(acc_upd_w), .ovf(ovf_w)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Drive one cycle of inputs, let the rising edge pass, sample 1ns later
    task automatic cyc(input logic e, input logic r, input logic [7:0] d, input logic c);
        en_in   = e;
        in_row  = r;
        in_data = d;
        acc_clr = c;
        @(posedge clk);
        #1;
        en_in   = 1'b0;
        in_row  = 1'b0;
        in_data = 8'd0;
        acc_clr = 1'b0;
    endtask

    task automatic row(input logic [7:0] v);
        cyc(1'b1, 1'b1, v, 1'b0);
    endtask

    task automatic issue(input logic [7:0] v);
        cyc(1'b1, 1'b0, v, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic clr();
        cyc(1'b0, 1'b0, 8'd0, 1'b1);
    endtask

    initial begin
        rstn    = 1'b0;
        en_in   = 1'b0;
        in_row  = 1'b0;
        in_data = 8'd0;
        acc_clr = 1'b0;
        en_out  = 1'b1;
        idle();
        idle();
        chk("reset_acc", out_data, 8'd0);
        chk("reset_ovf", 8'(ovf), 8'd0);
        chk("reset_upd", 8'(acc_upd), 8'd0);
        rstn = 1'b1;
        idle();

        // Basic: tap=8 (1.0), B=16 (2.0) -> 16
        row(8'd8); row(8'd16); row(8'd24);
        issue(8'd16);
        chk("basic_upd_n1", 8'(acc_upd), 8'd0);
        idle();
        chk("basic_acc_n1", out_data, 8'd0);
        idle();
        chk("basic_acc_n2", out_data, 8'd16);
        chk("basic_upd_n2", 8'(acc_upd), 8'd1);
        chk("basic_vld", 8'(out_vld), 8'd1);
        idle();
        chk("basic_upd_n3", 8'(acc_upd), 8'd0);
        chk("basic_acc_hold", out_data, 8'd16);

        // Rounding: -8*12 -> -12 ; 3*3 -> +1
        clr();
        chk("clr_acc", out_data, 8'd0);
        row(8'(-8)); row(8'd0); row(8'd0);
        issue(8'd12);
        idle(); idle();
        chk("neg_prod", out_data, 8'(-12));
        row(8'd3); row(8'd0); row(8'd0);
        issue(8'd3);
        idle(); idle();
        chk("round_up", out_data, 8'(-11));

        // Saturation vs wrap: 120 + 16
        clr();
        row(8'd8); row(8'd0); row(8'd0);
        issue(8'd120);
        idle(); idle();
        chk("sat_pre_acc", out_data, 8'd120);
        chk("wrap_pre_acc", out_data_w, 8'd120);
        chk("sat_pre_ovf", 8'(ovf), 8'd0);
        issue(8'd16);
        idle(); idle();
        chk("sat_acc", out_data, 8'd127);
        chk("sat_ovf", 8'(ovf), 8'd1);
        chk("wrap_acc", out_data_w, 8'(-120));
        chk("wrap_ovf", 8'(ovf_w), 8'd1);

        // Product clamp: 127*127 -> 127, then acc_clr alone
        clr();
        chk("clr_ovf", 8'(ovf), 8'd0);
        row(8'd127); row(8'd0); row(8'd0);
        issue(8'd127);
        idle();
        chk("pclamp_ovf", 8'(ovf), 8'd1);
        idle();
        chk("pclamp_acc", out_data, 8'd127);
        clr();
        chk("clr_alone_acc", out_data, 8'd0);
        chk("clr_alone_ovf", 8'(ovf), 8'd0);

        // acc_clr on the accumulate edge loads the product
        row(8'd8); row(8'd0); row(8'd0);
        issue(8'd50);
        idle(); idle();
        chk("acc50", out_data, 8'd50);
        issue(8'd10);
        idle();
        clr();
        chk("clr_add_acc", out_data, 8'd10);
        chk("clr_add_ovf", 8'(ovf), 8'd0);
        chk("clr_add_upd", 8'(acc_upd), 8'd1);

        // Back-to-back issues of product 8
        clr();
        issue(8'd8); issue(8'd8); issue(8'd8);
        chk("b2b_e3", out_data, 8'd8);
        idle();
        chk("b2b_e4", out_data, 8'd16);
        chk("b2b_upd_e4", 8'(acc_upd), 8'd1);
        idle();
        chk("b2b_e5", out_data, 8'd24);
        idle();
        chk("b2b_upd_e6", 8'(acc_upd), 8'd0);

        // Reset between issue and accumulate discards the in-flight product
        row(8'd127); row(8'd0); row(8'd0);
        issue(8'd127);
        idle();
        chk("rst_pre_ovf", 8'(ovf), 8'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_acc", out_data, 8'd0);
        chk("rst_async_ovf", 8'(ovf), 8'd0);
        #2 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("rst_no_upd", 8'(acc_upd), 8'd0);
            chk("rst_acc", out_data, 8'd0);
            chk("rst_ovf", 8'(ovf), 8'd0);
        end
        row(8'd8); row(8'd0); row(8'd0);
        issue(8'd16);
        idle(); idle();
        en_out = 1'b0;
        #1;
        chk("en_out0_data", out_data, 8'd0);
        chk("en_out0_vld", 8'(out_vld), 8'd0);
        en_out = 1'b1;
        #1;
        chk("post_rst_acc", out_data, 8'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fxp_mac_pe.md
FXP_MAC_PE -- requirements
Module: fxp_mac_pe

Interface
REQ-001 SHALL have parameter W, default 8: data/accumulator width, two's complement.
REQ-002 SHALL have parameter FRAC, default 3: fractional bits (LSB weight 2^-FRAC), 1 <= FRAC < W.
REQ-003 SHALL have parameter DEPTH, default 3: row-buffer depth, DEPTH >= 1.
REQ-004 SHALL have parameter SAT, default 1: 1 = saturating arithmetic, 0 = wrap-around.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port en_in  input  1  in_data valid this cycle.
REQ-008 SHALL have port in_row  input  1  1 = in_data is a row element, 0 = in_data is a multiplier operand.
REQ-009 SHALL have port in_data  input  W  two's-complement operand.
REQ-010 SHALL have port acc_clr  input  1  synchronous accumulator/flag clear.
REQ-011 SHALL have port en_out  input  1  output enable.
REQ-012 SHALL have port out_data  output  W  accumulator when en_out=1, else 0.
REQ-013 SHALL have port out_vld  output  1  equals en_out, registered-free.
REQ-014 SHALL have port acc_upd  output  1  one-cycle pulse: accumulator updated on the previous edge.
REQ-015 SHALL have port ovf  output  1  sticky overflow/saturation flag.

Function
REQ-016 SHALL, on en_in & in_row, shift in_data into buf[0] and buf[k] <= buf[k-1] for k = 1..DEPTH-1; tap = buf[DEPTH-1].
REQ-017 SHALL hold the buffer when en_in=0 or in_row=0.
REQ-018 SHALL, on en_in & ~in_row (issue edge N), register b_reg <= in_data, a_reg <= tap (pre-shift value), and iss <= 1; otherwise iss <= 0.
REQ-019 SHALL, at edge N+1 with iss=1, register p_reg = round((a_reg*b_reg) >> FRAC): full 2W-bit signed product, add 2^(FRAC-1), arithmetic shift right by FRAC; set p_vld <= 1.
REQ-020 SHALL, if the shifted product exceeds the W-bit signed range, clamp p_reg to 2^(W-1)-1 / -2^(W-1) when SAT=1, or truncate to W LSBs when SAT=0; set ovf in either case.
REQ-021 SHALL, at edge N+2 with p_vld=1, update acc <= acc + p_reg (clamped when SAT=1, wrapped when SAT=0), set ovf on signed overflow, and pulse acc_upd for one cycle.
REQ-022 SHALL accept back-to-back issues every cycle (throughput 1, latency 2 edges from issue to acc).
REQ-023 SHALL, on acc_clr with no accumulate on that edge, set acc <= 0 and ovf <= 0.
REQ-024 SHALL, on acc_clr coinciding with an accumulate edge, load acc <= p_reg (clear-then-add) and set ovf to that edge's overflow only.
REQ-025 SHALL drive out_data = acc when en_out=1, else all-zero; out_vld = en_out.

Reset
REQ-026 SHALL, while rstn=0, asynchronously clear buf[*], a_reg, b_reg, p_reg, acc, iss, p_vld, acc_upd and ovf to 0; in-flight products are discarded.
REQ-027 SHALL resume normal operation on the first rising clk edge after rstn deasserts.

Verification (W=8, FRAC=3)
REQ-028 SHALL pass: shift rows 8,16,24, issue B=16 at N -> acc=16 after N+2, acc_upd=1 in cycle N+2 only, out_data=16 with en_out=1.
REQ-029 SHALL pass: tap=-8, B=12 -> acc contribution -12; tap=3, B=3 -> 1 (9+4=13, >>3).
REQ-030 SHALL pass: SAT=1, acc=120, product 16 -> acc=127, ovf=1; SAT=0 same stimulus -> acc=-120, ovf=1.
REQ-031 SHALL pass: tap=127, B=127 -> p_reg clamped to 127 (SAT=1), ovf=1; acc_clr alone -> acc=0, ovf=0.
REQ-032 SHALL pass: acc=50, acc_clr asserted on accumulate edge with p_reg=10 -> acc=10; three back-to-back issues of product 8 -> acc=24 after final issue +2.
REQ-033 SHALL pass: rstn pulsed low between issue and accumulate -> acc=0, ovf=0, acc_upd never pulses; out_data=0 while en_out=0.
